// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 S1 entry arbiter: FSM states and source tags.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_N1 = 2'd1,
    LOCK_N3 = 2'd2
  } arb_state_t;

  localparam logic SRC_NOC1 = 1'b0;
  localparam logic SRC_NOC3 = 1'b1;

endpackage

// File: rtl/l2_pipe_arb_if.sv
// Bundle of the NoC1/NoC3 input queues, pipeline control and the S1 output flit.
interface l2_pipe_arb_if #(
  parameter int FLIT_W = 64,
  parameter int LEN_W  = 3
);
  logic              noc1_valid;
  logic [FLIT_W-1:0] noc1_data;
  logic [LEN_W-1:0]  noc1_len;
  logic              noc1_ready;

  logic              noc3_valid;
  logic [FLIT_W-1:0] noc3_data;
  logic [LEN_W-1:0]  noc3_len;
  logic              noc3_ready;

  logic              mshr_full;
  logic              stall_S1;

  logic              s1_valid;
  logic [FLIT_W-1:0] s1_data;
  logic              s1_src;
  logic              s1_hdr;
  logic              s1_last;

  // Upstream buffers and the pipeline side.
  modport master (
    output noc1_valid, noc1_data, noc1_len,
    input  noc1_ready,
    output noc3_valid, noc3_data, noc3_len,
    input  noc3_ready,
    output mshr_full, stall_S1,
    input  s1_valid, s1_data, s1_src, s1_hdr, s1_last
  );

  // The arbiter itself.
  modport slave (
    input  noc1_valid, noc1_data, noc1_len,
    output noc1_ready,
    input  noc3_valid, noc3_data, noc3_len,
    output noc3_ready,
    input  mshr_full, stall_S1,
    output s1_valid, s1_data, s1_src, s1_hdr, s1_last
  );
endinterface

// File: rtl/l2_arb_out_reg.sv
// S1 output register: loads on accept, holds under stall, drops valid when drained.
module l2_arb_out_reg #(
  parameter int FLIT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_stall,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_src,
  input  logic              i_hdr,
  input  logic              i_last,
  output logic              o_valid,
  output logic [FLIT_W-1:0] o_data,
  output logic              o_src,
  output logic              o_hdr,
  output logic              o_last
);

  logic              r_valid;
  logic [FLIT_W-1:0] r_data;
  logic              r_src;
  logic              r_hdr;
  logic              r_last;

  // The arbiter only asserts i_load when this register is free, so load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= 1'b0;
      r_hdr   <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_src   <= i_src;
      r_hdr   <= i_hdr;
      r_last  <= i_last;
    end else if (!i_stall) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_src   = r_src;
  assign o_hdr   = r_hdr;
  assign o_last  = r_last;

endmodule

// File: rtl/l2_pipe_arb.sv
// L2 S1 entry arbiter: NoC3-priority, whole-message grants, NoC1 starvation guard.
import l2_arb_pkg::*;

module l2_pipe_arb #(
  parameter int FLIT_W     = 64,
  parameter int LEN_W      = 3,
  parameter int STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst_n,
  l2_pipe_arb_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       r_state;
  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_starve;

  logic              w_s1_valid;
  logic              w_out_free;
  logic              w_n1_ok;
  logic              w_n1_wins;
  logic              w_gnt1;
  logic              w_gnt3;
  logic              w_accept;
  logic [FLIT_W-1:0] w_flit;
  logic [LEN_W-1:0]  w_len;
  logic              w_src;
  logic              w_hdr;
  logic              w_last;

  assign w_out_free = !w_s1_valid || !bus.stall_S1;
  assign w_n1_ok    = bus.noc1_valid && !bus.mshr_full;
  assign w_n1_wins  = w_n1_ok && (!bus.noc3_valid || (r_starve == CNT_W'(STARVE_MAX)));

  // Grants depend only on valids, mshr_full, stall and state; never on flit data.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt3 = 1'b0;
    if (rst_n && w_out_free) begin
      case (r_state)
        IDLE: begin
          w_gnt1 = w_n1_wins;
          w_gnt3 = !w_n1_wins && bus.noc3_valid;
        end
        LOCK_N1: w_gnt1 = bus.noc1_valid;
        LOCK_N3: w_gnt3 = bus.noc3_valid;
        default: begin
          w_gnt1 = 1'b0;
          w_gnt3 = 1'b0;
        end
      endcase
    end
  end

  assign bus.noc1_ready = w_gnt1;
  assign bus.noc3_ready = w_gnt3;

  assign w_accept = w_gnt1 || w_gnt3;
  assign w_flit   = w_gnt3 ? bus.noc3_data : bus.noc1_data;
  assign w_len    = w_gnt3 ? bus.noc3_len  : bus.noc1_len;
  assign w_src    = w_gnt3 ? SRC_NOC3 : SRC_NOC1;
  assign w_hdr    = (r_state == IDLE);
  assign w_last   = w_hdr ? (w_len == '0) : (r_rem == LEN_W'(1));

  // In a lock r_rem is always >= 1, since zero-length messages never lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_starve <= '0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_rem <= w_len;
        if (w_len != '0) begin
          r_state <= w_gnt3 ? LOCK_N3 : LOCK_N1;
        end
        if (w_gnt1) begin
          r_starve <= '0;
        end else if (w_n1_ok && (r_starve != CNT_W'(STARVE_MAX))) begin
          r_starve <= r_starve + CNT_W'(1);
        end
      end else begin
        r_rem <= r_rem - LEN_W'(1);
        if (r_rem == LEN_W'(1)) begin
          r_state <= IDLE;
        end
      end
    end
  end

  l2_arb_out_reg #(
    .FLIT_W(FLIT_W)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_stall(bus.stall_S1),
    .i_data (w_flit),
    .i_src  (w_src),
    .i_hdr  (w_hdr),
    .i_last (w_last),
    .o_valid(w_s1_valid),
    .o_data (bus.s1_data),
    .o_src  (bus.s1_src),
    .o_hdr  (bus.s1_hdr),
    .o_last (bus.s1_last)
  );

  assign bus.s1_valid = w_s1_valid;

endmodule

// File: tb/tb_l2_pipe_arb.sv
// Directed bench for l2_pipe_arb: message-level reference model checked every cycle plus literal pins.
module tb_l2_pipe_arb;
  localparam int FLIT_W     = 64;
  localparam int LEN_W      = 3;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_pipe_arb_if #(.FLIT_W(FLIT_W), .LEN_W(LEN_W)) bus ();

  l2_pipe_arb #(
    .FLIT_W(FLIT_W), .LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: who owns the open message, how many payload flits remain,
  // how many NoC1 losses in a row, and what flit S1 should currently show.
  int          m_owner;   // 0 = none, 1 = NoC1 message open, 3 = NoC3 message open
  int          m_left;
  int          m_starve;
  int          m_len;
  bit          m_free, m_n1ok, m_take1, m_take3;
  logic        e_valid, e_src, e_hdr, e_last;
  logic [63:0] e_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_left = 0; m_starve = 0;
      e_valid = 1'b0; e_data = '0; e_src = 1'b0; e_hdr = 1'b0; e_last = 1'b0;
      chk("rst_s1_valid", bus.s1_valid, 0);
      chk("rst_s1_data",  bus.s1_data,  0);
      chk("rst_ready1",   bus.noc1_ready, 0);
      chk("rst_ready3",   bus.noc3_ready, 0);
    end else begin
      chk("m_s1_valid", bus.s1_valid, e_valid);
      if (e_valid) begin
        chk("m_s1_data", bus.s1_data, e_data);
        chk("m_s1_src",  bus.s1_src,  e_src);
        chk("m_s1_hdr",  bus.s1_hdr,  e_hdr);
        chk("m_s1_last", bus.s1_last, e_last);
      end
      m_free  = !e_valid || !bus.stall_S1;
      m_n1ok  = bus.noc1_valid && !bus.mshr_full;
      m_take1 = 1'b0;
      m_take3 = 1'b0;
      if (m_free) begin
        if (m_owner == 0) begin
          if (m_n1ok && (!bus.noc3_valid || m_starve == STARVE_MAX)) m_take1 = 1'b1;
          else if (bus.noc3_valid) m_take3 = 1'b1;
        end else if (m_owner == 1) begin
          m_take1 = bus.noc1_valid;
        end else begin
          m_take3 = bus.noc3_valid;
        end
      end
      chk("m_noc1_ready", bus.noc1_ready, m_take1);
      chk("m_noc3_ready", bus.noc3_ready, m_take3);
      if (m_take1 || m_take3) begin
        e_valid = 1'b1;
        e_src   = m_take3;
        e_data  = m_take3 ? bus.noc3_data : bus.noc1_data;
        if (m_owner == 0) begin
          m_len  = int'(m_take3 ? bus.noc3_len : bus.noc1_len);
          e_hdr  = 1'b1;
          e_last = (m_len == 0);
          if (m_take1) m_starve = 0;
          else if (m_n1ok && m_starve < STARVE_MAX) m_starve++;
          m_left = m_len;
          if (m_len != 0) m_owner = m_take3 ? 3 : 1;
        end else begin
          e_hdr = 1'b0;
          m_left--;
          e_last = (m_left == 0);
          if (m_left == 0) m_owner = 0;
        end
        $display("accept t=%0t src=%0d data=0x%0h hdr=%0d last=%0d",
                 $time, e_src, e_data, e_hdr, e_last);
      end else if (m_free) begin
        e_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.noc1_valid = 1'b0; bus.noc1_data = '0; bus.noc1_len = '0;
    bus.noc3_valid = 1'b0; bus.noc3_data = '0; bus.noc3_len = '0;
    bus.mshr_full  = 1'b0; bus.stall_S1  = 1'b0;
  endtask

  task automatic n1(input logic [63:0] d, input int l);
    bus.noc1_valid = 1'b1; bus.noc1_data = d; bus.noc1_len = LEN_W'(l);
  endtask

  task automatic n3(input logic [63:0] d, input int l);
    bus.noc3_valid = 1'b1; bus.noc3_data = d; bus.noc3_len = LEN_W'(l);
  endtask

  initial begin
    idle_in();
    bus.noc1_valid = 1'b1;
    #2;
    chk("reset_s1_valid", bus.s1_valid, 0);
    chk("reset_ready1_gated", bus.noc1_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    idle_in();

    // Single-flit NoC1 header on an idle arbiter
    n1(64'hA5, 0);
    #2 chk("t1_ready1", bus.noc1_ready, 1);
    chk("t1_ready3", bus.noc3_ready, 0);
    tick();
    bus.noc1_valid = 1'b0;
    chk("t1_valid", bus.s1_valid, 1);
    chk("t1_src",   bus.s1_src, 0);
    chk("t1_hdr",   bus.s1_hdr, 1);
    chk("t1_last",  bus.s1_last, 1);
    chk("t1_data",  bus.s1_data, 64'hA5);
    tick();

    // NoC3 len=2 lock with NoC1 waiting; payload len fields are ignored
    n1(64'h11, 0);
    n3(64'h30, 2);
    #2 chk("t2_h_ready3", bus.noc3_ready, 1);
    chk("t2_h_ready1", bus.noc1_ready, 0);
    tick();
    n3(64'h31, 0);
    chk("t2_f0_data", bus.s1_data, 64'h30);
    chk("t2_f0_last", bus.s1_last, 0);
    #2 chk("t2_p1_ready3", bus.noc3_ready, 1);
    chk("t2_p1_ready1", bus.noc1_ready, 0);
    tick();
    n3(64'h32, 0);
    chk("t2_f1_data", bus.s1_data, 64'h31);
    #2 chk("t2_p2_ready1", bus.noc1_ready, 0);
    tick();
    bus.noc3_valid = 1'b0;
    chk("t2_f2_data", bus.s1_data, 64'h32);
    chk("t2_f2_last", bus.s1_last, 1);
    #2 chk("t2_n1_ready1", bus.noc1_ready, 1);
    tick();
    bus.noc1_valid = 1'b0;
    chk("t2_n1_data", bus.s1_data, 64'h11);
    chk("t2_n1_src",  bus.s1_src, 0);
    tick();

    // mshr_full blocks NoC1 headers but not NoC1 payload
    bus.mshr_full = 1'b1;
    n1(64'h40, 3);
    repeat (3) begin
      #2 chk("t3_mshr_block", bus.noc1_ready, 0);
      tick();
    end
    bus.mshr_full = 1'b0;
    #2 chk("t3_hdr_ready", bus.noc1_ready, 1);
    tick();
    chk("t3_hdr", bus.s1_hdr, 1);
    bus.mshr_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.noc1_data = 64'(64'h40 + k);
      #2 chk("t3_pay_ready", bus.noc1_ready, 1);
      tick();
      chk("t3_pay_last", bus.s1_last, (k == 3) ? 64'd1 : 64'd0);
    end
    idle_in();
    tick();

    // Four-cycle stall in the middle of a NoC3 len=3 message
    n3(64'h50, 3);
    tick();
    bus.noc3_data = 64'h51;
    tick();
    bus.noc3_data = 64'h52;
    bus.stall_S1  = 1'b1;
    repeat (4) begin
      #2 chk("t4_stall_ready3", bus.noc3_ready, 0);
      chk("t4_stall_ready1", bus.noc1_ready, 0);
      chk("t4_stall_hold", bus.s1_data, 64'h51);
      tick();
    end
    bus.stall_S1 = 1'b0;
    #2 chk("t4_release_ready3", bus.noc3_ready, 1);
    tick();
    chk("t4_next_data", bus.s1_data, 64'h52);
    bus.noc3_data = 64'h53;
    #2 chk("t4_last_ready3", bus.noc3_ready, 1);
    tick();
    chk("t4_last_data", bus.s1_data, 64'h53);
    chk("t4_last_last", bus.s1_last, 1);
    idle_in();
    tick();

    // Starvation guard: eight NoC3 wins, then one forced NoC1 win, repeating
    n1(64'h60, 0);
    n3(64'h70, 0);
    for (int k = 0; k < 18; k++) begin
      #2 chk("t5_starve_ready1", bus.noc1_ready, (k % 9 == 8) ? 64'd1 : 64'd0);
      chk("t5_starve_ready3", bus.noc3_ready, (k % 9 == 8) ? 64'd0 : 64'd1);
      tick();
    end
    idle_in();
    tick();

    // Asynchronous reset while a NoC3 message is locked with two flits left
    n3(64'h80, 3);
    tick();
    bus.noc3_data = 64'h81;
    tick();
    bus.noc3_data = 64'h82;
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_valid", bus.s1_valid, 0);
    chk("t6_rst_data",   bus.s1_data, 0);
    chk("t6_rst_src",    bus.s1_src, 0);
    chk("t6_rst_hdr",    bus.s1_hdr, 0);
    chk("t6_rst_last",   bus.s1_last, 0);
    chk("t6_rst_ready3", bus.noc3_ready, 0);
    tick();
    rst_n = 1'b1;
    idle_in();
    n1(64'h90, 0);
    #2 chk("t6_after_ready1", bus.noc1_ready, 1);
    tick();
    idle_in();
    chk("t6_after_data", bus.s1_data, 64'h90);
    chk("t6_after_hdr",  bus.s1_hdr, 1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/l2_pipe_arb.md
# l2_pipe_arb

Entry arbiter for the L2 pipeline S1 stage. It shares one S1 issue slot between the NoC3 response queue and the NoC1 request queue. Messages are multi-flit and the grant is held for a whole message. NoC3 has fixed priority, bounded by a starvation counter that protects NoC1. The block sits between the NoC input buffers and `pipe1`/`pipe2` S1, and produces one registered flit per cycle plus a source tag.

## Interface
- `FLIT_W`, default 64: flit width.
- `LEN_W`, default 3: width of the payload-flit count; a message is 1 header flit plus `len` payload flits.
- `STARVE_MAX`, default 8: consecutive NoC1 losses before NoC1 is forced a grant.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `noc1_valid` in 1: NoC1 flit available.
- `noc1_data` in `FLIT_W`: NoC1 flit.
- `noc1_len` in `LEN_W`: payload count; sampled only on a header flit.
- `noc1_ready` out 1: NoC1 flit accepted this cycle.
- `noc3_valid`, `noc3_data`, `noc3_len`, `noc3_ready`: same meaning, for NoC3.
- `mshr_full` in 1: blocks new NoC1 headers only; NoC1 payload flits are not blocked.
- `stall_S1` in 1: pipeline cannot take the S1 flit.
- `s1_valid` out 1: S1 flit valid.
- `s1_data` out `FLIT_W`: S1 flit.
- `s1_src` out 1: source of the S1 flit; 0 = NoC1, 1 = NoC3.
- `s1_hdr` out 1: S1 flit is a header.
- `s1_last` out 1: S1 flit is the last flit of its message.

## Operation
- The FSM has three states: `IDLE`, `LOCK_N1`, `LOCK_N3`.
- Output register readiness: `out_free = !s1_valid || !stall_S1`.
- `noc1_ready` and `noc3_ready` are never both 1. Neither is 1 when `out_free` is 0.
- **IDLE, header arbitration:**
  - `n1_ok = noc1_valid && !mshr_full`.
  - NoC1 wins if `n1_ok && (!noc3_valid || starve_cnt == STARVE_MAX)`.
  - Otherwise NoC3 wins if `noc3_valid`.
  - On a win, the winner's header is accepted and `rem` is loaded with its `len`.
  - If `len == 0`, the FSM stays in IDLE. Otherwise it moves to `LOCK_N1` or `LOCK_N3`.
- **LOCK_x:**
  - Only source x is granted.
  - Each accepted flit decrements `rem`.
  - The flit that takes `rem` from 1 to 0 is marked `s1_last`, and the FSM returns to IDLE.
  - A bubble on source x holds the lock. The other source does not interleave.
- **starve_cnt**, saturating at `STARVE_MAX`:
  - Increments when a NoC3 header is accepted while `n1_ok` is 1.
  - Clears when a NoC1 header is accepted.
  - Holds otherwise, including during locks.
- `mshr_full` asserting during `LOCK_N1` does not break the lock.
- **Output register:** loads on every accept. It clears `s1_valid` when `out_free` is 1 and nothing is accepted. It holds while `stall_S1` is 1.
- **Reset values** (immediate on `rst_n` falling):
  - FSM = IDLE, `rem` = 0, `starve_cnt` = 0.
  - `s1_valid` = 0, `s1_data` = 0, `s1_src` = 0, `s1_hdr` = 0, `s1_last` = 0.
  - `noc1_ready` = 0, `noc3_ready` = 0.
- Reset mid-message discards the partial message. Upstream buffers are reset together with this block.

## Timing
- Accept in cycle N puts the flit on `s1_*` in cycle N+1. Latency is 1 cycle.
- Sustained throughput is 1 flit/cycle with no bubbles, including back-to-back messages with IDLE re-arbitration in the same cycle as the previous `s1_last`.
- Ready outputs are combinational from `*_valid`, `mshr_full`, `stall_S1`, FSM and `starve_cnt`. There are no paths from `*_data`.
- Stall is released in cycle M. The held flit leaves and a new flit is accepted in the same cycle M.
- A single-flit message has `s1_hdr` = 1 and `s1_last` = 1 on the same flit.

## Structure
- Shared package `l2_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `LOCK_N1`, `LOCK_N3`).
  - Source encodings `SRC_NOC1` = 0, `SRC_NOC3` = 1.
- One sub-module, `l2_arb_out_reg`: the valid/stall output register holding data, src, hdr and last.
- Arbitration, FSM and counters live in the top module.

## Test plan
- **Idle NoC1 only:** NoC1 single-flit header `0xA5`, `len` = 0, no stall. Required: `noc1_ready` = 1; next cycle `s1_valid` = 1, `s1_src` = 0, `s1_hdr` = 1, `s1_last` = 1, `s1_data` = `0xA5`.
- **Lock:** NoC3 `len` = 2 message with NoC1 also valid. Required: 3 consecutive NoC3 flits on S1; no NoC1 flit interleaved; NoC1 header granted the cycle after the NoC3 last flit is accepted.
- **Starvation:** both sources continuously presenting single-flit headers, `STARVE_MAX` = 8. Required: 8 NoC3 grants, then 1 NoC1 grant, and the pattern repeats.
- **MSHR:** `mshr_full` = 1 with a NoC1 header only. Required: no grant, `starve_cnt` stays 0. Asserting `mshr_full` during `LOCK_N1` with `len` = 3: all 4 flits still issue.
- **Stall:** `stall_S1` = 1 for 4 cycles mid-message. Required: `s1_*` frozen, both readies 0; on release, a flit leaves and the next flit enters in the same cycle.
- **Reset mid-message:** assert `rst_n` = 0 in `LOCK_N3` with `rem` = 2. Required: outputs go to 0 immediately; after release, the FSM is in IDLE and the next header is arbitrated normally.
